iiitb_uart_rx: RTL and testbench

UART receiver paired with the baud rate generator: recovers 8N1 serial frames from an asynchronous line at one of four selectable rates using 16x oversampling from the 125 MHz system clock. It sits on the receive side of the serial link and presents each byte with a one-cycle valid strobe plus a framing-error strobe. The rate select encoding matches the generator's `sel`, so transmit and receive ends share a single configuration field.

---
 rtl/iiitb_uart_rx.sv | 165 ++++++++++++++++
 tb/tb_iiitb_uart_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_uart_rx.sv
// Purpose : 8N1 UART receiver, 16x oversampling, four selectable baud rates (sel matches baud generator).
// Latency : strobe one clock after the mid-stop-bit sample (~9.5 bit periods after the start edge).
// Backpres: none; rx_data/rx_valid is a fire-and-forget strobe, the consumer must take it that cycle.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   sel[1:0]  baud select (00=DIV0 .. 11=DIV3), latched at frame start
//   rx        serial line, idle high, asynchronous to clk
//   rx_data   last correctly framed byte
//   rx_valid  one-cycle strobe, rx_data updated
//   frame_err one-cycle strobe, stop bit sampled low
//   busy      frame in progress
module iiitb_uart_rx #(
    parameter int DIV0 = 68,
    parameter int DIV1 = 203,
    parameter int DIV2 = 407,
    parameter int DIV3 = 814
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state, state_n;

    logic        rx_s1, rx_s2, rx_prev;
    logic [1:0]  sel_q;
    logic [9:0]  os_cnt;
    logic [9:0]  div_m1;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    logic        fall;
    logic        tick;
    logic        load_sel;
    logic        start_ok;
    logic        sample_data;
    logic        stop_ok;
    logic        stop_bad;

    // Synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Only a genuine 1->0 transition starts a frame; a line stuck low (break) never does.
    assign fall = rx_prev & ~rx_s2;

    // Divisor comes from the latched select so mid-frame sel changes cannot skew sampling.
    always_comb begin
        div_m1 = 10'(DIV0 - 1);
        case (sel_q)
            2'b00:   div_m1 = 10'(DIV0 - 1);
            2'b01:   div_m1 = 10'(DIV1 - 1);
            2'b10:   div_m1 = 10'(DIV2 - 1);
            default: div_m1 = 10'(DIV3 - 1);
        endcase
    end

    assign tick = (state != IDLE) && (os_cnt == div_m1);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        load_sel    = 1'b0;
        start_ok    = 1'b0;
        sample_data = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_n  = START;
                    load_sel = 1'b1;
                end
            end
            START: begin
                // Mid start bit: line back high means the edge was a glitch.
                if (tick && tick_cnt == 4'd7) begin
                    if (rx_s2) begin
                        state_n = IDLE;
                    end else begin
                        state_n  = DATA;
                        start_ok = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick && tick_cnt == 4'd15) begin
                    sample_data = 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (tick && tick_cnt == 4'd15) begin
                    state_n = IDLE;
                    if (rx_s2) stop_ok  = 1'b1;
                    else       stop_bad = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q     <= 2'b00;
            os_cnt    <= 10'd0;
            tick_cnt  <= 4'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= stop_ok;
            frame_err <= stop_bad;

            if (load_sel) sel_q <= sel;

            if (state == IDLE || tick) os_cnt <= 10'd0;
            else                       os_cnt <= os_cnt + 10'd1;

            // Re-align the tick count to mid start bit so later bits sample at their centres.
            if (state == IDLE || start_ok) tick_cnt <= 4'd0;
            else if (tick)                 tick_cnt <= tick_cnt + 4'd1;

            if (state == IDLE)    bit_idx <= 3'd0;
            else if (sample_data) bit_idx <= bit_idx + 3'd1;

            // LSB arrives first, so shift in from the top.
            if (sample_data) shreg <= {rx_s2, shreg[7:1]};

            if (stop_ok) rx_data <= shreg;
        end
    end

endmodule

// File: tb/tb_iiitb_uart_rx.sv
// Purpose : directed self-checking bench for iiitb_uart_rx with scaled-down divisors.
// Latency : n/a (testbench).
// Backpres: n/a (testbench).
module tb_iiitb_uart_rx;

    localparam int D0 = 5;
    localparam int D1 = 7;
    localparam int D2 = 9;
    localparam int D3 = 12;
    localparam int B0 = 16 * D0;
    localparam int B1 = 16 * D1;
    localparam int B2 = 16 * D2;
    localparam int B3 = 16 * D3;

    logic       clk;
    logic       reset;
    logic [1:0] sel;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks;
    int failures;
    int cyc;
    int drive_cyc;
    int valid_cyc;
    int valid_cnt;
    int err_cnt;
    int excl_bad;
    int width_bad;
    logic prev_v;
    logic prev_e;
    logic [7:0] data_q[$];

    iiitb_uart_rx #(
        .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(posedge clk) cyc++;

    // Strobe monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            data_q.push_back(rx_data);
        end
        if (frame_err) err_cnt++;
        if (rx_valid && frame_err) excl_bad++;
        if ((rx_valid && prev_v) || (frame_err && prev_e)) width_bad++;
        prev_v = rx_valid;
        prev_e = frame_err;
    end

    task automatic send_byte(input logic [7:0] b, input int bitclk, input logic stopbit);
        @(negedge clk);
        rx = 1'b0;
        drive_cyc = cyc;
        repeat (bitclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bitclk) @(negedge clk);
        end
        rx = stopbit;
        repeat (bitclk) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rx    = 1'b1;
        sel   = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_55;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        data_q.delete();
        sel = 2'b00;
        send_byte(8'h55, B0, 1'b1);
        repeat (B0) @(negedge clk);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL s55_valid_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL s55_data got=%h exp=55", rx_data); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL s55_frame_err got=%0d exp=0", err_cnt - e0); end
        // 2 sync flops + FSM entry, then 152 ticks to the stop sample, strobe one clock later.
        checks++; if (valid_cyc - drive_cyc !== 3 + 152 * D0) begin failures++; $display("FAIL s55_latency got=%0d exp=%0d", valid_cyc - drive_cyc, 3 + 152 * D0); end
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        logic [7:0] d0, d1;
        v0 = valid_cnt; e0 = err_cnt;
        data_q.delete();
        sel = 2'b11;
        send_byte(8'hA3, B3, 1'b1);
        send_byte(8'h0F, B3, 1'b1);
        repeat (B3) @(negedge clk);
        d0 = (data_q.size() > 0) ? data_q[0] : 8'hxx;
        d1 = (data_q.size() > 1) ? data_q[1] : 8'hxx;
        checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0); end
        checks++; if (d0 !== 8'hA3) begin failures++; $display("FAIL b2b_first got=%h exp=a3", d0); end
        checks++; if (d1 !== 8'h0F) begin failures++; $display("FAIL b2b_second got=%h exp=0f", d1); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        sel = 2'b00;
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high got=%b exp=1", busy); end
        // Short of the mid start-bit sample point (8*D0 = 40 clocks).
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (3 * B0) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_low got=%b exp=0", busy); end
        checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_frame_err;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        sel = 2'b01;
        send_byte(8'hC3, B1, 1'b0);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", err_cnt - e0); end
        checks++; if (rx_data !== 8'h0F) begin failures++; $display("FAIL ferr_data_kept got=%h exp=0f", rx_data); end
        // Break: line stays low, must not restart.
        repeat (5 * B1) @(negedge clk);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL break_err_count got=%0d exp=1", err_cnt - e0); end
        checks++; if (valid_cnt - v0 !== 0) begin failures++; $display("FAIL break_valid got=%0d exp=0", valid_cnt - v0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_busy got=%b exp=0", busy); end
        rx = 1'b1;
        repeat (2 * B1) @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        int v0;
        sel = 2'b10;
        @(negedge clk);
        rx = 1'b0;
        repeat (B2) @(negedge clk);
        for (int i = 0; i < 4; i++) repeat (B2) @(negedge clk);
        rx = 1'b1;  // data bit 4 of 0x10
        repeat (B2 / 2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_mid_frame_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        v0 = valid_cnt;
        send_byte(8'h7E, B2, 1'b1);
        repeat (B2) @(negedge clk);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL rst_after_valid got=%0d exp=1", valid_cnt - v0); end
        checks++; if (rx_data !== 8'h7E) begin failures++; $display("FAIL rst_after_data got=%h exp=7e", rx_data); end
    endtask

    task automatic test_sel_change;
        int v0;
        v0 = valid_cnt;
        sel = 2'b00;
        fork
            send_byte(8'h96, B0, 1'b1);
            begin
                repeat (3 * B0 + B0 / 2) @(negedge clk);
                sel = 2'b11;  // middle of data bit 2
            end
        join
        repeat (B0) @(negedge clk);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL selchg_valid got=%0d exp=1", valid_cnt - v0); end
        checks++; if (rx_data !== 8'h96) begin failures++; $display("FAIL selchg_data got=%h exp=96", rx_data); end
        send_byte(8'h3C, B3, 1'b1);
        repeat (B3) @(negedge clk);
        checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL selchg_next_valid got=%0d exp=2", valid_cnt - v0); end
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL selchg_next_data got=%h exp=3c", rx_data); end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; drive_cyc = 0; valid_cyc = 0;
        valid_cnt = 0; err_cnt = 0; excl_bad = 0; width_bad = 0;
        prev_v = 1'b0; prev_e = 1'b0;
        reset = 1'b0; rx = 1'b1; sel = 2'b00;

        test_reset;
        test_single_55;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_midframe;
        test_sel_change;

        checks++; if (excl_bad !== 0) begin failures++; $display("FAIL strobe_exclusive got=%0d exp=0", excl_bad); end
        checks++; if (width_bad !== 0) begin failures++; $display("FAIL strobe_width got=%0d exp=0", width_bad); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
